// File: rtl/grid_pkg.sv
// rtl/grid_pkg.sv - shared sizes, op codes and FSM states for the grid row RAM arbiter
package grid_pkg;

    localparam int GRID_NREQ   = 3;
    localparam int GRID_DATA_W = 40;
    localparam int GRID_ADDR_W = 5;
    localparam int GRID_ROWS   = 31;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_TGL = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        WRBACK = 2'd3
    } grid_state_t;

endpackage

// File: rtl/grid_arb_pick.sv
// rtl/grid_arb_pick.sv - combinational winner select; round-robin when GRID_ARB_RR_EN is defined, else fixed priority
import grid_pkg::*;

module grid_arb_pick #(
    parameter int NREQ  = GRID_NREQ,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
`ifdef GRID_ARB_RR_EN
    input  logic [PTR_W-1:0] ptr,
`endif
    output logic             any,
    output logic [PTR_W-1:0] win
);

`ifdef GRID_ARB_RR_EN
    int idx;

    // ptr is the first index to consider; the first set bit from there wins
    always_comb begin
        any = 1'b0;
        win = '0;
        idx = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any && req[idx]) begin
                any = 1'b1;
                win = PTR_W'(idx);
            end
        end
    end
`else
    // Scanning downwards lets the lowest set index overwrite the others
    always_comb begin
        any = 1'b0;
        win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                any = 1'b1;
                win = PTR_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/grid_ram_arbiter.sv
// rtl/grid_ram_arbiter.sv - serialises read/write/toggle requests onto the single-port life-grid row RAM (GRID_ARB_RR_EN selects round-robin)
import grid_pkg::*;

module grid_ram_arbiter #(
    parameter int NREQ   = GRID_NREQ,
    parameter int DATA_W = GRID_DATA_W,
    parameter int ADDR_W = GRID_ADDR_W,
    parameter int ROWS   = GRID_ROWS
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req,
    input  logic [2*NREQ-1:0]      op,
    input  logic [ADDR_W*NREQ-1:0] addr,
    input  logic [DATA_W*NREQ-1:0] wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic                   err,
    output logic                   rvalid,
    output logic [DATA_W-1:0]      rdata,
    output logic                   busy,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [DATA_W-1:0]      ram_data,
    output logic                   ram_wren,
    input  logic [DATA_W-1:0]      ram_q
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    grid_state_t       state, state_nxt;
    logic [1:0]        op_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] mod_r;
    logic [PTR_W-1:0]  win_r;
    logic [PTR_W-1:0]  pick_win;
    logic              pick_any;
    logic [NREQ-1:0]   done_c;
    logic              addr_bad;
    logic              is_wr;
    logic              is_tgl;

    assign addr_bad = 32'(addr_r) >= 32'(ROWS);
    assign is_wr    = op_r == OP_WR;
    assign is_tgl   = op_r == OP_TGL;
    assign busy     = state != IDLE;

    // Read completion is registered, so it arrives while the FSM is already back in IDLE
    assign done = done_c | ({NREQ{rvalid}} & (NREQ'(1) << win_r));

`ifdef GRID_ARB_RR_EN
    logic [PTR_W-1:0] ptr_r;

    grid_arb_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
        .req (req),
        .ptr (ptr_r),
        .any (pick_any),
        .win (pick_win)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_r <= '0;
        end else if (state == IDLE && pick_any) begin
            ptr_r <= (pick_win == PTR_W'(NREQ - 1)) ? '0 : pick_win + PTR_W'(1);
        end
    end
`else
    grid_arb_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
        .req (req),
        .any (pick_any),
        .win (pick_win)
    );
`endif

    always_comb begin
        state_nxt = state;
        gnt       = '0;
        done_c    = '0;
        err       = 1'b0;
        ram_addr  = '0;
        ram_data  = '0;
        ram_wren  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    gnt       = NREQ'(1) << pick_win;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                ram_addr = addr_r;
                if (addr_bad) begin
                    done_c    = NREQ'(1) << win_r;
                    err       = 1'b1;
                    state_nxt = IDLE;
                end else if (is_wr) begin
                    ram_wren  = 1'b1;
                    ram_data  = wdata_r;
                    done_c    = NREQ'(1) << win_r;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = RDWAIT;
                end
            end
            RDWAIT: begin
                ram_addr  = addr_r;
                state_nxt = is_tgl ? WRBACK : IDLE;
            end
            WRBACK: begin
                ram_addr  = addr_r;
                ram_data  = mod_r;
                ram_wren  = 1'b1;
                done_c    = NREQ'(1) << win_r;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            op_r    <= '0;
            addr_r  <= '0;
            wdata_r <= '0;
            mod_r   <= '0;
            win_r   <= '0;
            rdata   <= '0;
            rvalid  <= 1'b0;
        end else begin
            state  <= state_nxt;
            rvalid <= 1'b0;
            if (state == IDLE && pick_any) begin
                op_r    <= op[int'(pick_win)*2 +: 2];
                addr_r  <= addr[int'(pick_win)*ADDR_W +: ADDR_W];
                wdata_r <= wdata[int'(pick_win)*DATA_W +: DATA_W];
                win_r   <= pick_win;
            end
            if (state == RDWAIT) begin
                if (is_tgl) begin
                    mod_r <= ram_q ^ wdata_r;
                end else begin
                    rdata  <= ram_q;
                    rvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_grid_ram_arbiter.sv
// tb/tb_grid_ram_arbiter.sv - transaction-timeline model plus directed vectors for grid_ram_arbiter
module tb_grid_ram_arbiter;
    import grid_pkg::*;

    localparam int NREQ = 3;
    localparam int DW   = 40;
    localparam int AW   = 5;

    logic              clk     = 1'b0;
    logic              reset_n = 1'b0;
    logic [NREQ-1:0]   req     = '0;
    logic [2*NREQ-1:0] op      = '0;
    logic [AW*NREQ-1:0] addr   = '0;
    logic [DW*NREQ-1:0] wdata  = '0;
    logic [NREQ-1:0]   gnt, done;
    logic              err, rvalid, busy, ram_wren;
    logic [DW-1:0]     rdata, ram_data;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_q = '0;

    grid_ram_arbiter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .op       (op),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .busy     (busy),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_wren (ram_wren),
        .ram_q    (ram_q)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [0:31];
    always @(posedge clk) begin
        if (ram_wren) ram[ram_addr] <= ram_data;
        ram_q <= ram[ram_addr];
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Model: each grant books its future events on a cycle timeline
    logic [DW-1:0]   shadow [0:31];
    bit              model_on = 1'b0;
    bit              hold     = 1'b0;
    int              free_at  = 0;
    int              rr_next  = 0;
    logic [NREQ-1:0] e_done  [int];
    bit              e_err   [int];
    bit              e_busy  [int];
    bit              e_rv    [int];
    logic [DW-1:0]   e_rdata [int];
    bit              e_wr    [int];
    logic [AW-1:0]   e_waddr [int];
    logic [DW-1:0]   e_wdata [int];

    int              gnt_log[$];
    int              gnt_cyc[$];
    int              done_cyc[$];
    int              err_cyc[$];
    int              rv_cyc[$];
    logic [DW-1:0]   rv_data[$];
    int              wren_cnt = 0;
    logic [NREQ-1:0] gnt_last = '0;

    int              m_w, m_a, m_start;
    logic [1:0]      m_op;
    logic [DW-1:0]   m_d;
    logic [NREQ-1:0] m_g;

    always @(negedge clk) begin
        if (model_on) begin
            m_g = '0;
            if (reset_n && cyc >= free_at && req != '0) begin
`ifdef GRID_ARB_RR_EN
                m_start = rr_next;
`else
                m_start = 0;
`endif
                m_w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (m_w < 0 && req[(m_start + k) % NREQ]) m_w = (m_start + k) % NREQ;
                end
                rr_next   = (m_w + 1) % NREQ;
                m_g[m_w]  = 1'b1;
                m_op      = op[m_w*2 +: 2];
                m_a       = int'(addr[m_w*AW +: AW]);
                m_d       = wdata[m_w*DW +: DW];
                if (m_a >= 31) begin
                    e_done[cyc+1] = m_g; e_err[cyc+1] = 1'b1; e_busy[cyc+1] = 1'b1;
                    free_at = cyc + 2;
                end else if (m_op == 2'b01) begin
                    e_done[cyc+1] = m_g; e_busy[cyc+1] = 1'b1;
                    e_wr[cyc+1] = 1'b1; e_waddr[cyc+1] = AW'(m_a); e_wdata[cyc+1] = m_d;
                    free_at = cyc + 2;
                end else if (m_op == 2'b10) begin
                    e_done[cyc+3] = m_g;
                    for (int k = 1; k <= 3; k++) e_busy[cyc+k] = 1'b1;
                    e_wr[cyc+3] = 1'b1; e_waddr[cyc+3] = AW'(m_a); e_wdata[cyc+3] = shadow[m_a] ^ m_d;
                    free_at = cyc + 4;
                end else begin
                    e_done[cyc+3] = m_g; e_rv[cyc+3] = 1'b1; e_rdata[cyc+3] = shadow[m_a];
                    e_busy[cyc+1] = 1'b1; e_busy[cyc+2] = 1'b1;
                    free_at = cyc + 3;
                end
            end
            chk("gnt", 64'(gnt), 64'(m_g));
            chk("done", 64'(done), e_done.exists(cyc) ? 64'(e_done[cyc]) : 64'd0);
            chk("err", 64'(err), 64'(e_err.exists(cyc)));
            chk("busy", 64'(busy), 64'(e_busy.exists(cyc)));
            chk("rvalid", 64'(rvalid), 64'(e_rv.exists(cyc)));
            chk("ram_wren", 64'(ram_wren), 64'(e_wr.exists(cyc)));
            if (e_rv.exists(cyc)) chk("rdata", 64'(rdata), 64'(e_rdata[cyc]));
            if (e_wr.exists(cyc)) begin
                chk("ram_addr", 64'(ram_addr), 64'(e_waddr[cyc]));
                chk("ram_data", 64'(ram_data), 64'(e_wdata[cyc]));
                shadow[e_waddr[cyc]] = e_wdata[cyc];
            end else begin
                chk("ram_data_idle", 64'(ram_data), 64'd0);
            end
            if (!reset_n) begin
                for (int k = 1; k <= 4; k++) begin
                    e_done.delete(cyc+k); e_err.delete(cyc+k); e_busy.delete(cyc+k);
                    e_rv.delete(cyc+k); e_rdata.delete(cyc+k); e_wr.delete(cyc+k);
                    e_waddr.delete(cyc+k); e_wdata.delete(cyc+k);
                end
                free_at = cyc + 1;
                rr_next = 0;
            end
            gnt_last = gnt;
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) begin gnt_log.push_back(i); gnt_cyc.push_back(cyc); end
            end
            if (done != '0) done_cyc.push_back(cyc);
            if (err) err_cyc.push_back(cyc);
            if (rvalid) begin rv_cyc.push_back(cyc); rv_data.push_back(rdata); end
            if (ram_wren) wren_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (!hold) req = req & ~gnt_last;
    endtask

    task automatic settle(input int n);
        repeat (n) step();
    endtask

    task automatic wait_grants(input int n, input int maxc);
        int k;
        k = 0;
        while (gnt_log.size() < n && k < maxc) begin
            step();
            k++;
        end
        if (gnt_log.size() < n) chk("grant_timeout", 64'(gnt_log.size()), 64'(n));
    endtask

    task automatic clear_logs();
        gnt_log.delete(); gnt_cyc.delete(); done_cyc.delete(); err_cyc.delete();
        rv_cyc.delete(); rv_data.delete(); wren_cnt = 0;
    endtask

    int exp_order [6];

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = 40'(i) * 40'h01_0101_0101;
        ram[5]  = 40'h00_0000_00F0;
        ram[30] = 40'hA5_5A5A_A55A;
        ram[31] = 40'hDE_AD00_BEEF;
        for (int i = 0; i < 32; i++) shadow[i] = ram[i];

        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_on = 1'b1;
        reset_n  = 1'b1;
        @(negedge clk);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_ram_wren", 64'(ram_wren), 64'd0);

        // Three simultaneous writes
        clear_logs();
        op    = {OP_WR, OP_WR, OP_WR};
        addr  = {5'd6, 5'd4, 5'd2};
        wdata = {40'h33_3333_3333, 40'h22_2222_2222, 40'h11_1111_1111};
        req   = 3'b111;
        wait_grants(3, 20);
        settle(4);
        chk("wr_order0", 64'(gnt_log[0]), 64'd0);
        chk("wr_order1", 64'(gnt_log[1]), 64'd1);
        chk("wr_order2", 64'(gnt_log[2]), 64'd2);
        chk("wr_spacing", 64'(gnt_cyc[1] - gnt_cyc[0]), 64'd2);
        chk("row2", 64'(ram[2]), 64'h11_1111_1111);
        chk("row4", 64'(ram[4]), 64'h22_2222_2222);
        chk("row6", 64'(ram[6]), 64'h33_3333_3333);

        // Toggle row 5
        clear_logs();
        op[1:0] = OP_TGL; addr[4:0] = 5'd5; wdata[39:0] = 40'h00_0000_0018;
        req = 3'b001;
        wait_grants(1, 10);
        settle(6);
        chk("tgl_row5", 64'(ram[5]), 64'h00_0000_00E8);
        chk("tgl_latency", 64'(done_cyc[0] - gnt_cyc[0]), 64'd3);
        chk("tgl_wrens", 64'(wren_cnt), 64'd1);

        // Read row 30 from requester 2
        clear_logs();
        op[5:4] = OP_RD; addr[14:10] = 5'd30;
        req = 3'b100;
        wait_grants(1, 10);
        settle(6);
        chk("rd_latency", 64'(rv_cyc[0] - gnt_cyc[0]), 64'd3);
        chk("rd_data", 64'(rv_data[0]), 64'hA5_5A5A_A55A);
        chk("rd_done_with_rvalid", 64'(done_cyc[0]), 64'(rv_cyc[0]));

        // Illegal row 31 write
        clear_logs();
        op[3:2] = OP_WR; addr[9:5] = 5'd31; wdata[79:40] = 40'h12_3456_789A;
        req = 3'b010;
        wait_grants(1, 10);
        settle(4);
        chk("ill_err_count", 64'(err_cyc.size()), 64'd1);
        chk("ill_err_with_done", 64'(err_cyc[0]), 64'(done_cyc[0]));
        chk("ill_latency", 64'(err_cyc[0] - gnt_cyc[0]), 64'd1);
        chk("ill_no_wren", 64'(wren_cnt), 64'd0);
        chk("ill_row31", 64'(ram[31]), 64'hDE_AD00_BEEF);

        // Reserved op behaves as a read
        clear_logs();
        op[1:0] = 2'b11; addr[4:0] = 5'd2;
        req = 3'b001;
        wait_grants(1, 10);
        settle(5);
        chk("rsv_rdata", 64'(rv_data[0]), 64'h11_1111_1111);
        chk("rsv_no_wren", 64'(wren_cnt), 64'd0);

        // Reset while a toggle sits in RDWAIT
        clear_logs();
        op[1:0] = OP_TGL; addr[4:0] = 5'd5; wdata[39:0] = 40'h00_0000_00FF;
        req = 3'b001;
        wait_grants(1, 10);
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        chk("rst_mid_wren", 64'(ram_wren), 64'd0);
        chk("rst_mid_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_mid_rdata", 64'(rdata), 64'd0);
        settle(6);
        chk("rst_mid_row5", 64'(ram[5]), 64'h00_0000_00E8);
        chk("rst_mid_no_done", 64'(done_cyc.size()), 64'd0);
        chk("rst_mid_no_wren", 64'(wren_cnt), 64'd0);

        // Held requests: arbitration order over six transactions
        clear_logs();
        hold  = 1'b1;
        op    = {OP_WR, OP_WR, OP_WR};
        addr  = {5'd12, 5'd11, 5'd10};
        wdata = {40'hCC_0000_000C, 40'hBB_0000_000B, 40'hAA_0000_000A};
        req   = 3'b111;
        wait_grants(6, 40);
        req  = 3'b000;
        hold = 1'b0;
        settle(4);
`ifdef GRID_ARB_RR_EN
        exp_order = '{0, 1, 2, 0, 1, 2};
`else
        exp_order = '{0, 0, 0, 0, 0, 0};
`endif
        for (int i = 0; i < 6; i++) chk($sformatf("order%0d", i), 64'(gnt_log[i]), 64'(exp_order[i]));
        chk("order_row10", 64'(ram[10]), 64'hAA_0000_000A);

        settle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
